// File: rtl/traffic_pkg.sv
// Shared definitions for the N-phase traffic controller.
// Contents: lamp codes for one {R,Y,G} lamp group, the controller state
// encoding, and small constant helpers used to size counters.
package traffic_pkg;

  // Lamp codes, bit order {R,Y,G}
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  typedef enum logic [1:0] {
    S_ALLRED = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_FLASH  = 2'd3
  } state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int width_for(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_controller_nphase_rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
// Given a request vector and the index of the phase last served, returns the
// first requesting index in the order cur+1, cur+2, ..., wrapping, with cur
// itself considered last.
// Ports:
//   req      in   N        pending requests
//   cur      in   IW       index of the phase last served
//   next_idx out  IW       selected index (cur when nothing is pending)
//   valid    out  1        at least one request is pending
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] cur,
  output logic [IW-1:0] next_idx,
  output logic          valid
);

  logic [IW-1:0] idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional update, otherwise the tool infers a latch to hold it.
    next_idx = cur;
    valid    = 1'b0;
    idx      = '0;
    // Scan from farthest to nearest so the nearest requester overwrites.
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(cur) + k) % N);
      if (req[idx]) begin
        next_idx = idx;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_controller_nphase.sv
// traffic_controller_nphase: sequences NUM_PHASES conflicting approaches with
// sensor-actuated greens, round-robin service of latched requests, walk
// lamps and a flashing maintenance mode. All durations are prescaled ticks.
// Ports:
//   clk_100MHz  in   1             system clock
//   reset_n     in   1             asynchronous active-low reset
//   car_req     in   NUM_PHASES    level vehicle sensors
//   ped_req     in   NUM_PHASES    pedestrian buttons (pulse or level)
//   flash_mode  in   1             1 = flashing maintenance mode
//   lights      out  3*NUM_PHASES  {R,Y,G} per phase, phase i at [3i+2:3i]
//   walk        out  NUM_PHASES    walk lamp per phase
//   cur_phase   out  3             phase currently green or last served
//   tick        out  1             one-cycle prescaler strobe
module traffic_controller_nphase
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES  = 3,
  parameter int TICK_CYCLES = 100_000_000,
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 8,
  parameter int YELLOW_T    = 2,
  parameter int ALLRED_T    = 1,
  parameter int WALK_T      = 3,
  parameter int FLASH_T     = 1
) (
  input  logic                    clk_100MHz,
  input  logic                    reset_n,
  input  logic [NUM_PHASES-1:0]   car_req,
  input  logic [NUM_PHASES-1:0]   ped_req,
  input  logic                    flash_mode,
  output logic [3*NUM_PHASES-1:0] lights,
  output logic [NUM_PHASES-1:0]   walk,
  output logic [2:0]              cur_phase,
  output logic                    tick
);

  localparam int PW = $clog2(NUM_PHASES);
  localparam int CW = width_for(TICK_CYCLES - 1);
  localparam int TW = width_for(max_of(max_of(GREEN_MAX, YELLOW_T),
                                       max_of(ALLRED_T, FLASH_T)));

  // ---------------- prescaler ----------------
  logic [CW-1:0] pre_cnt;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt == CW'(TICK_CYCLES - 1)) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + CW'(1);
      tick    <= 1'b0;
    end
  end

  // ---------------- state ----------------
  state_t                  state;
  logic [PW-1:0]           phase;     // phase green, or last served
  logic [TW-1:0]           tmr;       // down-count in ALLRED/YELLOW/FLASH, elapsed in GREEN
  logic                    force0;    // next green is phase 0 (after reset / flash)
  logic                    flash_on;
  logic [NUM_PHASES-1:0]   req_l;
  logic [NUM_PHASES-1:0]   ped_l;

  // ---------------- decision logic ----------------
  logic [PW-1:0]           arb_next;
  logic                    arb_valid;
  logic [PW-1:0]           green_idx;
  logic                    enter_green;
  logic                    tmr_done;
  logic [TW-1:0]           el_nxt;
  logic [NUM_PHASES-1:0]   phase_mask;
  logic                    other_req;
  logic                    ped_win;

  rr_arbiter #(.N(NUM_PHASES), .IW(PW)) u_arb (
    .req      (req_l),
    .cur      (phase),
    .next_idx (arb_next),
    .valid    (arb_valid)
  );

  assign green_idx   = force0 ? '0 : (arb_valid ? arb_next : phase);
  assign tmr_done    = (tmr <= TW'(1));
  assign enter_green = tick && (state == S_ALLRED) && tmr_done && !flash_mode;
  // Elapsed green ticks including the tick being processed, saturating.
  assign el_nxt      = (tmr >= TW'(GREEN_MAX)) ? TW'(GREEN_MAX) : tmr + TW'(1);
  assign phase_mask  = NUM_PHASES'(1) << phase;
  assign other_req   = |(req_l & ~phase_mask);
  // A button press on the entry cycle still earns a walk.
  assign ped_win     = ped_l[green_idx] | ped_req[green_idx];
  assign cur_phase   = 3'(phase);

  function automatic logic [3*NUM_PHASES-1:0] lamps_one(input logic [PW-1:0] p,
                                                        input logic [2:0]    code);
    for (int i = 0; i < NUM_PHASES; i++)
      lamps_one[3*i +: 3] = (PW'(i) == p) ? code : L_RED;
  endfunction

  function automatic logic [3*NUM_PHASES-1:0] lamps_flash(input logic on);
    for (int i = 0; i < NUM_PHASES; i++)
      lamps_flash[3*i +: 3] = !on ? L_OFF : ((i == 0) ? L_YEL : L_RED);
  endfunction

  // ---------------- request latches ----------------
  // Clearing on green entry takes priority, so a request arriving on that
  // same cycle counts as served.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      req_l <= '0;
      ped_l <= '0;
    end else begin
      for (int i = 0; i < NUM_PHASES; i++) begin
        if (enter_green && (green_idx == PW'(i))) begin
          req_l[i] <= 1'b0;
          ped_l[i] <= 1'b0;
        end else if (!((state == S_GREEN) && (phase == PW'(i)))) begin
          if (car_req[i] || ped_req[i]) req_l[i] <= 1'b1;
          if (ped_req[i])               ped_l[i] <= 1'b1;
        end
      end
    end
  end

  // ---------------- FSM with registered lamp outputs ----------------
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_ALLRED;
      tmr      <= TW'(ALLRED_T);
      phase    <= '0;
      force0   <= 1'b1;
      flash_on <= 1'b0;
      lights   <= {NUM_PHASES{L_RED}};
      walk     <= '0;
    end else if (tick) begin
      case (state)
        S_ALLRED: begin
          if (!tmr_done) begin
            tmr <= tmr - TW'(1);
          end else if (flash_mode) begin
            state    <= S_FLASH;
            tmr      <= TW'(FLASH_T);
            flash_on <= 1'b1;
            lights   <= lamps_flash(1'b1);
            walk     <= '0;
          end else begin
            state  <= S_GREEN;
            phase  <= green_idx;
            tmr    <= '0;
            force0 <= 1'b0;
            lights <= lamps_one(green_idx, L_GRN);
            walk   <= (ped_win && (WALK_T > 0)) ? (NUM_PHASES'(1) << green_idx) : '0;
          end
        end
        S_GREEN: begin
          tmr <= el_nxt;
          if (el_nxt >= TW'(WALK_T)) walk <= '0;
          if ((el_nxt >= TW'(GREEN_MIN)) &&
              (flash_mode ||
               (other_req && (!car_req[phase] || (el_nxt >= TW'(GREEN_MAX)))))) begin
            state  <= S_YELLOW;
            tmr    <= TW'(YELLOW_T);
            lights <= lamps_one(phase, L_YEL);
            walk   <= '0;
          end
        end
        S_YELLOW: begin
          if (tmr_done) begin
            state  <= S_ALLRED;
            tmr    <= TW'(ALLRED_T);
            lights <= {NUM_PHASES{L_RED}};
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_FLASH: begin
          if (!flash_mode) begin
            state    <= S_ALLRED;
            tmr      <= TW'(ALLRED_T);
            force0   <= 1'b1;
            flash_on <= 1'b0;
            lights   <= {NUM_PHASES{L_RED}};
          end else if (tmr_done) begin
            flash_on <= ~flash_on;
            tmr      <= TW'(FLASH_T);
            lights   <= lamps_flash(~flash_on);
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        default: begin
          state  <= S_ALLRED;
          tmr    <= TW'(ALLRED_T);
          lights <= {NUM_PHASES{L_RED}};
          walk   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_controller_nphase.sv
// Directed bench for traffic_controller_nphase (3 phases, 10-cycle tick).
// Outputs are sampled on the falling clock edge; lamp vectors read {p2,p1,p0}.
module tb_traffic_controller_nphase;

  localparam int TICK = 10;

  localparam logic [8:0] ALL_R  = 9'b100_100_100;
  localparam logic [8:0] G0     = 9'b100_100_001;
  localparam logic [8:0] Y0     = 9'b100_100_010;
  localparam logic [8:0] G1     = 9'b100_001_100;
  localparam logic [8:0] Y1     = 9'b100_010_100;
  localparam logic [8:0] G2     = 9'b001_100_100;
  localparam logic [8:0] Y2     = 9'b010_100_100;
  localparam logic [8:0] FL_ON  = 9'b100_100_010;
  localparam logic [8:0] FL_OFF = 9'b000_000_000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] car_req;
  logic [2:0] ped_req;
  logic       flash_mode;
  logic [8:0] lights;
  logic [2:0] walk;
  logic [2:0] cur_phase;
  logic       tick;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  traffic_controller_nphase #(
    .NUM_PHASES  (3),
    .TICK_CYCLES (TICK)
  ) dut (
    .clk_100MHz (clk),
    .reset_n    (reset_n),
    .car_req    (car_req),
    .ped_req    (ped_req),
    .flash_mode (flash_mode),
    .lights     (lights),
    .walk       (walk),
    .cur_phase  (cur_phase),
    .tick       (tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Consume n tick strobes; return at the falling edge after the last one,
  // when the controller's decision for that tick is visible.
  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      while (tick !== 1'b1 && guard <= 3 * TICK) begin
        @(negedge clk);
        guard++;
      end
      if (guard > 3 * TICK) begin
        vectors++;
        miscompares++;
        $error("FAIL tick_wait: no tick strobe within %0d cycles", 3 * TICK);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse(input logic [2:0] car_m, input logic [2:0] ped_m);
    car_req = car_req | car_m;
    ped_req = ped_req | ped_m;
    @(negedge clk);
    car_req = car_req & ~car_m;
    ped_req = ped_req & ~ped_m;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    car_req    = '0;
    ped_req    = '0;
    flash_mode = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_lights", 32'(lights), 32'(ALL_R));
    check("rst_walk", 32'(walk), 32'd0);
    check("rst_cur_phase", 32'(cur_phase), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("allred_before_tick", 32'(lights), 32'(ALL_R));
    tick_wait(1);
    check("first_green_p0", 32'(lights), 32'(G0));
    check("first_cur_phase", 32'(cur_phase), 32'd0);

    // No requests: phase 0 rests in green
    for (int i = 0; i < 50; i++) begin
      tick_wait(1);
      check("rest_green_p0", 32'(lights), 32'(G0));
    end

    // Asynchronous reset, then restart for a fresh phase-0 green (g0)
    reset_n = 1'b0;
    #1;
    check("async_rst_from_green", 32'(lights), 32'(ALL_R));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    tick_wait(1);
    check("g0_green_p0", 32'(lights), 32'(G0));

    // car_req[2] at green tick 1: min green, yellow 2, allred 1, green p2
    tick_wait(1);
    pulse(3'b100, 3'b000);
    tick_wait(2);
    check("g3_min_green_hold", 32'(lights), 32'(G0));
    tick_wait(1);
    check("g4_yellow_p0", 32'(lights), 32'(Y0));
    tick_wait(1);
    check("g5_yellow_p0", 32'(lights), 32'(Y0));
    tick_wait(1);
    check("g6_allred", 32'(lights), 32'(ALL_R));
    tick_wait(1);
    check("g7_green_p2", 32'(lights), 32'(G2));
    check("g7_cur_phase", 32'(cur_phase), 32'd2);

    // From phase 2 with 0 and 1 pending: 0 is next
    pulse(3'b011, 3'b000);
    tick_wait(4);
    check("g11_yellow_p2", 32'(lights), 32'(Y2));
    tick_wait(2);
    check("g13_allred", 32'(lights), 32'(ALL_R));
    tick_wait(1);
    check("g14_green_p0_wrap", 32'(lights), 32'(G0));
    check("g14_cur_phase", 32'(cur_phase), 32'd0);
    check("g14_walk_off", 32'(walk), 32'd0);

    // From phase 0 with 1 and 2 pending: 1 then 2; ped on 1 gives a walk
    pulse(3'b100, 3'b010);
    tick_wait(4);
    check("g18_yellow_p0", 32'(lights), 32'(Y0));
    tick_wait(3);
    check("g21_green_p1", 32'(lights), 32'(G1));
    check("g21_cur_phase", 32'(cur_phase), 32'd1);
    check("g21_walk_on", 32'(walk), 32'b010);
    tick_wait(2);
    check("g23_walk_still_on", 32'(walk), 32'b010);
    tick_wait(1);
    check("g24_walk_off", 32'(walk), 32'd0);
    check("g24_green_p1", 32'(lights), 32'(G1));
    tick_wait(1);
    check("g25_yellow_p1", 32'(lights), 32'(Y1));
    tick_wait(3);
    check("g28_green_p2", 32'(lights), 32'(G2));
    check("g28_walk_off", 32'(walk), 32'd0);

    // car_req[0] held: phase 0 extends to GREEN_MAX when 1 is waiting
    car_req = 3'b001;
    tick_wait(4);
    check("g32_yellow_p2", 32'(lights), 32'(Y2));
    tick_wait(3);
    check("g35_green_p0", 32'(lights), 32'(G0));
    pulse(3'b010, 3'b000);
    tick_wait(7);
    check("g42_green_p0_extended", 32'(lights), 32'(G0));
    tick_wait(1);
    check("g43_yellow_at_max", 32'(lights), 32'(Y0));
    car_req = 3'b000;
    tick_wait(3);
    check("g46_green_p1", 32'(lights), 32'(G1));
    check("g46_cur_phase", 32'(cur_phase), 32'd1);
    check("g46_walk_off", 32'(walk), 32'd0);

    // Flash mode at elapsed 5
    tick_wait(5);
    check("g51_green_p1", 32'(lights), 32'(G1));
    flash_mode = 1'b1;
    tick_wait(1);
    check("g52_flash_yellow_p1", 32'(lights), 32'(Y1));
    tick_wait(2);
    check("g54_flash_allred", 32'(lights), 32'(ALL_R));
    tick_wait(1);
    check("g55_flash_on", 32'(lights), 32'(FL_ON));
    check("g55_flash_walk", 32'(walk), 32'd0);
    tick_wait(1);
    check("g56_flash_off", 32'(lights), 32'(FL_OFF));
    tick_wait(1);
    check("g57_flash_on", 32'(lights), 32'(FL_ON));
    flash_mode = 1'b0;
    tick_wait(1);
    check("g58_unflash_allred", 32'(lights), 32'(ALL_R));
    tick_wait(1);
    check("g59_green_p0", 32'(lights), 32'(G0));
    check("g59_cur_phase", 32'(cur_phase), 32'd0);

    // Reset in the middle of a yellow
    pulse(3'b010, 3'b000);
    tick_wait(4);
    check("g63_yellow_p0", 32'(lights), 32'(Y0));
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async_rst_mid_yellow", 32'(lights), 32'(ALL_R));
    check("async_rst_walk", 32'(walk), 32'd0);
    check("async_rst_cur_phase", 32'(cur_phase), 32'd0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
